apb_cmd_initiator: RTL and testbench

- APB requester (master) that turns a simple valid/ready command stream into single APB3 transfers, with results returned on a valid/ready response stream.
- Sits between a host-side agent (debug bridge or DMA-like sequencer) and APB peripherals such as the LED register slave.
- One outstanding transfer at a time; no pipelining across transfers.

---
 rtl/apb_cmd_initiator.sv | 126 ++++++++++++
 tb/tb_apb_cmd_initiator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_initiator
// Purpose  : valid/ready command stream to single APB3 transfers, one at a time.
//            Define APB_TIMEOUT_EN to build in the ACCESS-phase timeout abort.
// Revision : 1.0
// ============================================================================
module apb_cmd_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_write ? cmd_wdata : '0;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          // pslverr only means something while pready is high
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
`ifdef APB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state     <= S_RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_initiator.sv
`default_nettype none
// Testbench for apb_cmd_initiator: directed plan steps plus randomized transfers
// checked against a transaction-level expectation of each response.
module tb_apb_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_cmd_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer; expected response derived from the transaction itself.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input bit slverr, input int waits,
                         input int hold, input bit busy_valid);
    logic [31:0] exp_rdata;
    logic [31:0] exp_pwdata;
    exp_rdata  = wr ? 32'h0 : rdata;
    exp_pwdata = wr ? wdata : 32'h0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'b0; rsp_ready = 1'($urandom);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_psel", psel, 0);
    tick();
    cmd_valid = busy_valid; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, exp_pwdata);
    tick();
    for (int i = 0; i <= waits; i++) begin
      check("access_psel", psel, 1);
      check("access_penable", penable, 1);
      check("access_paddr", paddr, addr);
      check("access_pwdata", pwdata, exp_pwdata);
      check("access_rsp_valid", rsp_valid, 0);
      pready  = (i == waits);
      prdata  = (i == waits) ? rdata : $urandom;
      pslverr = (i == waits) ? slverr : 1'($urandom);
      rsp_ready = 1'($urandom);
      tick();
    end
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom); rsp_ready = 1'b0;
    check("resp_psel", psel, 0);
    check("resp_penable", penable, 0);
    check("resp_valid", rsp_valid, 1);
    check("resp_rdata", rsp_rdata, exp_rdata);
    check("resp_err", rsp_err, slverr);
    check("resp_timeout", rsp_timeout, 0);
    check("resp_cmd_ready", cmd_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_err", rsp_err, slverr);
      check("hold_psel", psel, 0);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check("done_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_psel", psel, 0);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    tick(); tick();
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);

    // Plan: zero-wait write, 3-wait read, slave error, held response with cmd_valid high
    run_txn(1'b1, 32'h8000_0000, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h8000_0000, 32'h1111_1111, 32'h0000_0080, 1'b0, 3, 0, 1'b0);
    run_txn(1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b1, 0, 0, 1'b0);
    run_txn(1'b1, 32'h8000_0008, 32'h5A5A_5A5A, 32'h0, 1'b0, 1, 5, 1'b1);
    run_txn(1'b0, 32'h0000_0003, 32'h0, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_0010; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_penable", penable, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_psel", psel, 0);
    check("async_penable", penable, 0);
    check("async_rsp_valid", rsp_valid, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_psel", psel, 0);
    run_txn(1'b1, 32'h8000_0000, 32'h0000_003C, 32'h0, 1'b0, 2, 1, 1'b0);

`ifdef APB_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8000_0020; pready = 1'b0;
    prdata = 32'hCAFE_F00D;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      check("to_penable", penable, 1);
      check("to_psel", psel, 1);
      tick();
    end
    check("to_drop_psel", psel, 0);
    check("to_drop_penable", penable, 0);
    check("to_valid", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_timeout", rsp_timeout, 1);
    check("to_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_done_cmd_ready", cmd_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
